// File: rtl/rc4_pkg.sv
// rc4_pkg
// Shared types and constants for the RC4 key-scheduling sequencer.
//   byte_t         : 8-bit data/address type used for S-memory traffic
//   state_t        : sequencer FSM state encoding
//   KEY_LENGTH_DEF : default number of key bytes consumed per key cycle
package rc4_pkg;

  typedef logic [7:0] byte_t;

  localparam int KEY_LENGTH_DEF = 3;

  typedef enum logic [3:0] {
    IDLE,
    RD_I,
    WT_I,
    CAP_I,
    RD_J,
    WT_J,
    CAP_J,
    WR_I,
    WR_J,
    ADV,
    DONE
  } state_t;

endpackage

// File: rtl/ksa_key_byte_select.sv
// ksa_key_byte_select
// Picks one byte of the 24-bit secret key by key index (combinational).
// Ports:
//   i_secret_key [23:0] : key, byte 0 = [23:16], byte 1 = [15:8], byte 2 = [7:0]
//   i_key_idx    [1:0]  : key byte index (0..2; 3 returns 0)
//   o_key_byte   [7:0]  : selected key byte
module ksa_key_byte_select
  import rc4_pkg::*;
(
  input  logic [23:0] i_secret_key,
  input  logic [1:0]  i_key_idx,
  output logic [7:0]  o_key_byte
);

  always_comb begin
    o_key_byte = '0;
    case (i_key_idx)
      2'd0:    o_key_byte = i_secret_key[23:16];
      2'd1:    o_key_byte = i_secret_key[15:8];
      2'd2:    o_key_byte = i_secret_key[7:0];
      default: o_key_byte = '0;
    endcase
  end

endmodule

// File: rtl/ksa_swap_sequencer.sv
// ksa_swap_sequencer
// Runs the RC4 key-scheduling pass over a 256-entry S memory that the
// upstream block has already filled with the identity permutation.
// Reads are sampled two cycles after the address is first driven, so any
// memory with read latency of up to 2 cycles works.
// Ports:
//   clk          : clock, rising edge
//   reset_n      : asynchronous active-low reset
//   start        : run request, honoured only in IDLE or DONE
//   secret_key   : 24-bit key, byte 0 in [23:16]
//   mem_q        : S-memory read data
//   mem_address  : S-memory address
//   mem_data     : S-memory write data
//   mem_wren     : S-memory write enable
//   busy         : high while a run is in progress
//   done         : high in DONE until the next accepted start
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start after reset
// RD_I  | address = i, read issued
// WT_I  | address = i, read latency
// CAP_I | capture si, j += S[i] + key byte
// RD_J  | address = j, read issued
// WT_J  | address = j, read latency
// CAP_J | capture sj
// WR_I  | S[i] <= sj
// WR_J  | S[j] <= si (wins when i == j)
// ADV   | step i and key index, or finish after i == 255
// DONE  | run complete, waiting for start
module ksa_swap_sequencer
  import rc4_pkg::*;
#(
  parameter int KEY_LENGTH = KEY_LENGTH_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [23:0] secret_key,
  input  logic [7:0]  mem_q,
  output logic [7:0]  mem_address,
  output logic [7:0]  mem_data,
  output logic        mem_wren,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] KIDX_LAST = 2'(KEY_LENGTH - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_i;
  logic [7:0]  r_j;
  logic [7:0]  r_si;
  logic [7:0]  r_sj;
  logic [1:0]  r_kidx;
  logic [7:0]  w_key_byte;
  logic        w_idle_or_done;

  ksa_key_byte_select u_key_sel (
    .i_secret_key (secret_key),
    .i_key_idx    (r_kidx),
    .o_key_byte   (w_key_byte)
  );

  assign w_idle_or_done = (r_state == IDLE) || (r_state == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = start ? RD_I : IDLE;
      RD_I:    w_state_nxt = WT_I;
      WT_I:    w_state_nxt = CAP_I;
      CAP_I:   w_state_nxt = RD_J;
      RD_J:    w_state_nxt = WT_J;
      WT_J:    w_state_nxt = CAP_J;
      CAP_J:   w_state_nxt = WR_I;
      WR_I:    w_state_nxt = WR_J;
      WR_J:    w_state_nxt = ADV;
      ADV:     w_state_nxt = (r_i == 8'hFF) ? DONE : RD_I;
      DONE:    w_state_nxt = start ? RD_I : DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_i    <= '0;
      r_j    <= '0;
      r_si   <= '0;
      r_sj   <= '0;
      r_kidx <= '0;
    end else begin
      if (w_idle_or_done && start) begin
        r_i    <= '0;
        r_j    <= '0;
        r_kidx <= '0;
      end
      if (r_state == CAP_I) begin
        r_si <= mem_q;
        // 8-bit sum wraps naturally mod 256
        r_j  <= r_j + mem_q + w_key_byte;
      end
      if (r_state == CAP_J) begin
        r_sj <= mem_q;
      end
      if ((r_state == ADV) && (r_i != 8'hFF)) begin
        r_i    <= r_i + 8'd1;
        r_kidx <= (r_kidx == KIDX_LAST) ? 2'd0 : r_kidx + 2'd1;
      end
    end
  end

  always_comb begin
    mem_address = '0;
    mem_data    = '0;
    mem_wren    = 1'b0;
    case (r_state)
      RD_I, WT_I, CAP_I: mem_address = r_i;
      RD_J, WT_J, CAP_J: mem_address = r_j;
      WR_I: begin
        mem_address = r_i;
        mem_data    = r_sj;
        mem_wren    = 1'b1;
      end
      WR_J: begin
        mem_address = r_j;
        mem_data    = r_si;
        mem_wren    = 1'b1;
      end
      default: begin
        mem_address = '0;
        mem_data    = '0;
        mem_wren    = 1'b0;
      end
    endcase
  end

  assign busy = !w_idle_or_done;
  assign done = (r_state == DONE);

endmodule

// File: tb/tb_ksa_swap_sequencer.sv
// tb_ksa_swap_sequencer
// Two sequencer instances (3-byte and 1-byte keys), each with a 2-cycle
// read-latency S memory. A software KSA model fills a queue of expected
// writes; every write the DUT issues is popped and compared.
module tb_ksa_swap_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load_id;
  logic        start_a, start_b;
  logic [23:0] key_a, key_b;
  logic [7:0]  mq_a, addr_a, data_a, rd1_a;
  logic [7:0]  mq_b, addr_b, data_b, rd1_b;
  logic        wren_a, busy_a, done_a;
  logic        wren_b, busy_b, done_b;

  logic [7:0]  mem_a [256];
  logic [7:0]  mem_b [256];
  logic [7:0]  exp_s [256];
  logic [15:0] q_a [$];
  logic [15:0] q_b [$];
  logic [15:0] log_a [4];
  logic [15:0] log_b [4];
  int          wr_cnt_a, wr_cnt_b;
  int          n_total = 0;
  int          n_bad   = 0;

  always #5 clk = ~clk;

  ksa_swap_sequencer #(.KEY_LENGTH(3)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .secret_key(key_a),
    .mem_q(mq_a), .mem_address(addr_a), .mem_data(data_a),
    .mem_wren(wren_a), .busy(busy_a), .done(done_a)
  );

  ksa_swap_sequencer #(.KEY_LENGTH(1)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .secret_key(key_b),
    .mem_q(mq_b), .mem_address(addr_b), .mem_data(data_b),
    .mem_wren(wren_b), .busy(busy_b), .done(done_b)
  );

  // S memories: synchronous write, 2-cycle pipelined read
  always @(posedge clk) begin
    if (load_id) begin
      for (int k = 0; k < 256; k++) begin
        mem_a[k] <= 8'(k);
        mem_b[k] <= 8'(k);
      end
    end else begin
      if (wren_a) mem_a[addr_a] <= data_a;
      if (wren_b) mem_b[addr_b] <= data_b;
    end
    rd1_a <= mem_a[addr_a];
    mq_a  <= rd1_a;
    rd1_b <= mem_b[addr_b];
    mq_b  <= rd1_b;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // write scoreboards
  always @(negedge clk) begin
    logic [15:0] e;
    if (wren_a) begin
      chk("a_wr_expected", 32'(q_a.size() != 0), 32'd1);
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        chk("a_wr", 32'({addr_a, data_a}), 32'(e));
      end
      if (wr_cnt_a < 4) log_a[wr_cnt_a] = {addr_a, data_a};
      wr_cnt_a++;
    end
    if (wren_b) begin
      chk("b_wr_expected", 32'(q_b.size() != 0), 32'd1);
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        chk("b_wr", 32'({addr_b, data_b}), 32'(e));
      end
      if (wr_cnt_b < 4) log_b[wr_cnt_b] = {addr_b, data_b};
      wr_cnt_b++;
    end
  end

  // software KSA starting from the current memory contents
  task automatic model_run(input bit which, input int klen, input logic [23:0] key);
    logic [7:0] s [256];
    logic [7:0] j, si, sj, kb;
    int kidx;
    for (int k = 0; k < 256; k++) s[k] = which ? mem_b[k] : mem_a[k];
    j = 8'd0;
    for (int i = 0; i < 256; i++) begin
      kidx = i % klen;
      kb = (kidx == 0) ? key[23:16] : (kidx == 1) ? key[15:8] : key[7:0];
      j  = j + s[i] + kb;
      si = s[i];
      sj = s[j];
      if (which) begin
        q_b.push_back({8'(i), sj});
        q_b.push_back({j, si});
      end else begin
        q_a.push_back({8'(i), sj});
        q_a.push_back({j, si});
      end
      s[i] = sj;
      s[j] = si;
    end
    for (int k = 0; k < 256; k++) exp_s[k] = s[k];
  endtask

  // pulse start, check the first RD_I, time the run to DONE;
  // poke >= 0 re-pulses start once that many writes have been seen
  task automatic run_and_time(input bit which, input int poke, input string tag);
    int  cyc;
    bit  poked;
    poked = 1'b0;
    @(posedge clk); #1;
    if (which) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    chk({tag, "_busy_rd_i"}, 32'(which ? busy_b : busy_a), 32'd1);
    chk({tag, "_first_addr"}, 32'(which ? addr_b : addr_a), 32'd0);
    cyc = 0;
    while (!(which ? done_b : done_a) && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (poke >= 0 && !poked && wr_cnt_a == poke) begin
        start_a = 1'b1;
        poked = 1'b1;
      end else begin
        start_a = 1'b0;
      end
    end
    chk({tag, "_run_len"}, 32'(cyc), 32'd2304);
  endtask

  task automatic post_done(input bit which, input string tag);
    repeat (5) @(posedge clk);
    #1;
    chk({tag, "_done_hold"}, 32'(which ? done_b : done_a), 32'd1);
    chk({tag, "_busy_done"}, 32'(which ? busy_b : busy_a), 32'd0);
    chk({tag, "_addr_done"}, 32'(which ? addr_b : addr_a), 32'd0);
    chk({tag, "_data_done"}, 32'(which ? data_b : data_a), 32'd0);
    chk({tag, "_wren_done"}, 32'(which ? wren_b : wren_a), 32'd0);
    chk({tag, "_q_drained"}, 32'(which ? q_b.size() : q_a.size()), 32'd0);
    for (int k = 0; k < 256; k++)
      chk({tag, "_final_s"}, 32'(which ? mem_b[k] : mem_a[k]), 32'(exp_s[k]));
  endtask

  initial begin
    int guard;
    reset_n  = 1'b0;
    start_a  = 1'b0;
    start_b  = 1'b0;
    load_id  = 1'b0;
    key_a    = 24'h00035F;
    key_b    = 24'hFF0000;
    wr_cnt_a = 0;
    wr_cnt_b = 0;
    repeat (2) @(posedge clk);
    #1 load_id = 1'b1;
    @(posedge clk); #1 load_id = 1'b0;

    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_wren", 32'(wren_a), 32'd0);
    chk("rst_addr", 32'(addr_a), 32'd0);
    chk("rst_data", 32'(data_a), 32'd0);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("idle_no_start", 32'(busy_a), 32'd0);

    // run A: 3-byte key, restart attempt mid-run at i=10
    model_run(1'b0, 3, key_a);
    wr_cnt_a = 0;
    run_and_time(1'b0, 21, "A");
    chk("A_w0", 32'(log_a[0]), 32'h0000);
    chk("A_w1", 32'(log_a[1]), 32'h0000);
    chk("A_w2", 32'(log_a[2]), 32'h0104);
    chk("A_w3", 32'(log_a[3]), 32'h0401);
    post_done(1'b0, "A");

    // run B: reset during WR_I at i=100, then a fresh full run
    model_run(1'b0, 3, key_a);
    wr_cnt_a = 0;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    guard = 0;
    while (!(wr_cnt_a == 200 && wren_a) && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("B_reach_wr_i100", 32'(guard < 3000), 32'd1);
    chk("B_addr_wr_i100", 32'(addr_a), 32'd100);
    reset_n = 1'b0;
    #1;
    chk("B_rst_wren", 32'(wren_a), 32'd0);
    chk("B_rst_busy", 32'(busy_a), 32'd0);
    chk("B_rst_done", 32'(done_a), 32'd0);
    chk("B_rst_addr", 32'(addr_a), 32'd0);
    q_a.delete();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("B_idle_after_rst", 32'(busy_a), 32'd0);
    model_run(1'b0, 3, key_a);
    wr_cnt_a = 0;
    run_and_time(1'b0, -1, "B");
    post_done(1'b0, "B");

    // run C: single-byte key on the second instance
    model_run(1'b1, 1, key_b);
    wr_cnt_b = 0;
    run_and_time(1'b1, -1, "C");
    chk("C_w0", 32'(log_b[0]), 32'h00FF);
    chk("C_w1", 32'(log_b[1]), 32'hFF00);
    post_done(1'b1, "C");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
